// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the DataMemory arbiter: owner encoding, port
// indices and the DataMemory depth.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } ownerT;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DMEM_WORDS = 256;

endpackage

// File: rtl/rr_lock_arbiter2.sv
// Two-port round-robin arbiter with a bus lock and a starvation bound.
// Grants are combinational from the registered lastGnt/owner/lockCnt.
// Optional macro DMEM_ARB_STATS_EN adds the forcedRelease output.
module rr_lock_arbiter2
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  output logic gnt0,
  output logic gnt1
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic forcedRelease
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             lastGnt;
  ownerT            owner;
  logic [CNT_W-1:0] lockCnt;
  logic             hold0;
  logic             hold1;
  logic             lockedGrant;

  // A lock only holds while the owner has not yet used up its starvation budget.
  assign hold0 = (owner == OWN_P0) && (lockCnt < LIMIT);
  assign hold1 = (owner == OWN_P1) && (lockCnt < LIMIT);

  assign lockedGrant = req0 && req1 && ((hold0 && gnt0) || (hold1 && gnt1));

`ifdef DMEM_ARB_STATS_EN
  assign forcedRelease = !rst && req0 && req1 && (owner != OWN_NONE) && (lockCnt == LIMIT);
`endif

  // Pick at most one port: a lone request wins, then a valid lock, then round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && !req1) begin
        gnt0 = 1'b1;
      end else if (!req0 && req1) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (hold0) begin
          gnt0 = 1'b1;
        end else if (hold1) begin
          gnt1 = 1'b1;
        end else if (lastGnt == PORT0) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end
    end
  end

  // Track the last winner, the lock owner and how long the other port has waited on the lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGnt <= PORT1;
      owner   <= OWN_NONE;
      lockCnt <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        lastGnt <= gnt1 ? PORT1 : PORT0;
      end
      if (gnt0 && lock0) begin
        owner <= OWN_P0;
      end else if (gnt1 && lock1) begin
        owner <= OWN_P1;
      end else begin
        owner <= OWN_NONE;
      end
      if (lockedGrant) begin
        lockCnt <= (lockCnt == LIMIT) ? lockCnt : lockCnt + 1'b1;
      end else begin
        lockCnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DataMemory between the CPU (port 0) and the
// loader (port 1). Commands are issued in the grant cycle; read data
// returns one cycle later on the shared rdata bus.
// Optional macro DMEM_ARB_STATS_EN adds conflict_cnt and starve_rel_cnt.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              lock0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic              stall0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [7:0]        starve_rel_cnt
`endif
);

`ifdef DMEM_ARB_STATS_EN
  logic forcedRelease;
`endif

  rr_lock_arbiter2 #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) arbiter (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req1         (req1),
    .lock0        (lock0),
    .lock1        (lock1),
    .gnt0         (gnt0),
    .gnt1         (gnt1)
`ifdef DMEM_ARB_STATS_EN
    ,
    .forcedRelease(forcedRelease)
`endif
  );

  assign stall0 = req0 & ~gnt0;

  // Steer the granted port onto the memory; port 0 drives the bus when idle.
  always_comb begin
    mem_addr  = addr0;
    mem_wdata = wdata0;
    if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
    mem_write = (gnt0 & we0) | (gnt1 & we1);
    mem_read  = (gnt0 & ~we0) | (gnt1 & ~we1);
  end

  // Capture read data at the grant edge and flag the owning port for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (mem_read) begin
        rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating counters of contended cycles and of locks broken by the starvation bound.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt   <= '0;
      starve_rel_cnt <= '0;
    end else begin
      if (req0 && req1 && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (forcedRelease && (starve_rel_cnt != 8'hFF)) begin
        starve_rel_cnt <= starve_rel_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
